// File: rtl/microwave_controller_pl.sv
// Microwave controller: keypad BCD entry, countdown with power-level duty cycle, door interlock, pause/resume, DONE.
// Latency: button events act two edges after the press is first sampled; door open gates mag_on combinationally.
// Backpressure: none; all buttons are level inputs sampled every cycle, and events arriving in ignored states are dropped.
// Ports: clock/clearn; keypad[9:0], startn, stopn, power_key, door_closed in;
//        mag_on, sec_ones, sec_tens, mins, power_level, done, state out.
module microwave_controller_pl #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MIN_DIGITS    = 1,
    parameter int POWER_LEVELS  = 4
) (
    input  logic                                clock,
    input  logic                                clearn,
    input  logic [9:0]                          keypad,
    input  logic                                startn,
    input  logic                                stopn,
    input  logic                                power_key,
    input  logic                                door_closed,
    output logic                                mag_on,
    output logic [3:0]                          sec_ones,
    output logic [3:0]                          sec_tens,
    output logic [4*MIN_DIGITS-1:0]             mins,
    output logic [$clog2(POWER_LEVELS+1)-1:0]   power_level,
    output logic                                done,
    output logic [2:0]                          state
);

    localparam int ND = MIN_DIGITS + 2;             // total BCD digits
    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam int SW = $clog2(POWER_LEVELS);
    localparam int PW = $clog2(POWER_LEVELS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          cur_state, nxt_state;
    logic [4*ND-1:0] time_q, time_n, time_dec, time_shift, time_fresh;
    logic [TW-1:0]   tick_q, tick_n;
    logic [SW-1:0]   slot_q, slot_n;
    logic [PW-1:0]   power_q, power_n;
    logic            mag_q, mag_n;

    // Two-deep sample of every button; events compare the two samples.
    logic [9:0] key_q, key_qq;
    logic       startn_q, startn_qq, stopn_q, stopn_qq, pwr_q, pwr_qq;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            key_q     <= '0;
            key_qq    <= '0;
            startn_q  <= 1'b1;
            startn_qq <= 1'b1;
            stopn_q   <= 1'b1;
            stopn_qq  <= 1'b1;
            pwr_q     <= 1'b0;
            pwr_qq    <= 1'b0;
        end else begin
            key_q     <= keypad;
            key_qq    <= key_q;
            startn_q  <= startn;
            startn_qq <= startn_q;
            stopn_q   <= stopn;
            stopn_qq  <= stopn_q;
            pwr_q     <= power_key;
            pwr_qq    <= pwr_q;
        end
    end

    logic       key_ev, start_ev, stop_ev, pwr_ev;
    logic [3:0] key_val;

    // A key counts only when the new pattern is a single key that was not already held.
    assign key_ev   = $onehot(key_q) && (|(key_q & ~key_qq));
    assign start_ev = startn_qq & ~startn_q;
    assign stop_ev  = stopn_qq & ~stopn_q;
    assign pwr_ev   = pwr_q & ~pwr_qq;

    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_q[i]) key_val = 4'(i);
        end
    end

    logic time_zero, dec_zero, tick_end, borrow;

    assign time_zero  = (time_q == '0);
    assign tick_end   = (tick_q == TW'(TICKS_PER_SEC - 1));
    assign time_shift = {time_q[4*ND-5:0], key_val};     // top minute digit falls off
    assign time_fresh = {{(4*ND-4){1'b0}}, key_val};     // DONE clears before shifting

    // Single-second BCD decrement; the seconds-tens digit borrows to 5, all others to 9.
    always_comb begin
        time_dec = time_q;
        borrow   = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (time_q[4*i +: 4] == 4'd0) begin
                    time_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    time_dec[4*i +: 4] = time_q[4*i +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
    end

    assign dec_zero = (time_dec == '0);

    // FSM: state register
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) cur_state <= S_IDLE;
        else         cur_state <= nxt_state;
    end

    // FSM: next state; event priority is stop > start > key > power
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE, S_ENTRY: begin
                if (stop_ev)                           nxt_state = S_IDLE;
                else if (start_ev) begin
                    if (door_closed && !time_zero)     nxt_state = S_COOK;
                end
                else if (key_ev)                       nxt_state = S_ENTRY;
            end
            S_COOK: begin
                if (!door_closed || stop_ev)           nxt_state = S_PAUSED;
                else if (tick_end && dec_zero)         nxt_state = S_DONE;
            end
            S_PAUSED: begin
                if (stop_ev)                           nxt_state = S_IDLE;
                else if (start_ev && door_closed)      nxt_state = S_COOK;
            end
            S_DONE: begin
                if (stop_ev || start_ev)               nxt_state = S_IDLE;
                else if (key_ev)                       nxt_state = S_ENTRY;
            end
            default:                                   nxt_state = S_IDLE;
        endcase
    end

    // Datapath next values, same priority as the FSM
    always_comb begin
        time_n  = time_q;
        tick_n  = tick_q;
        slot_n  = slot_q;
        power_n = power_q;
        case (cur_state)
            S_IDLE, S_ENTRY: begin
                if (stop_ev) time_n = '0;
                else if (start_ev) begin
                    if (door_closed && !time_zero) begin
                        tick_n = '0;
                        slot_n = '0;
                    end
                end
                else if (key_ev) time_n = time_shift;
                else if (pwr_ev) power_n = (power_q == PW'(POWER_LEVELS)) ? PW'(1) : power_q + 1'b1;
            end
            S_COOK: begin
                // An open door freezes the countdown even on a terminal tick.
                if (door_closed && !stop_ev) begin
                    if (tick_end) begin
                        tick_n = '0;
                        time_n = time_dec;
                        slot_n = (slot_q == SW'(POWER_LEVELS - 1)) ? '0 : slot_q + 1'b1;
                    end else begin
                        tick_n = tick_q + 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (stop_ev) time_n = '0;
                else if (start_ev && door_closed) tick_n = '0;   // slot kept so the duty frame resumes
            end
            S_DONE: begin
                if (stop_ev || start_ev) time_n = '0;
                else if (key_ev) time_n = time_fresh;
            end
            default: time_n = '0;
        endcase
        mag_n = (nxt_state == S_COOK) && (PW'(slot_n) < power_q);
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            time_q  <= '0;
            tick_q  <= '0;
            slot_q  <= '0;
            power_q <= PW'(POWER_LEVELS);
            mag_q   <= 1'b0;
        end else begin
            time_q  <= time_n;
            tick_q  <= tick_n;
            slot_q  <= slot_n;
            power_q <= power_n;
            mag_q   <= mag_n;
        end
    end

    // FSM: outputs; the door term bypasses the register for an immediate interlock
    always_comb begin
        state  = cur_state;
        done   = (cur_state == S_DONE);
        mag_on = mag_q & door_closed;
    end

    assign sec_ones    = time_q[3:0];
    assign sec_tens    = time_q[7:4];
    assign mins        = time_q[4*ND-1:8];
    assign power_level = power_q;

endmodule

// File: doc/microwave_controller_pl.md
Name: microwave_controller_pl

Overview:
- Parametrised next-generation microwave controller.
- Integrates keypad digit entry, BCD countdown timer, door interlock and magnetron control in one clocked block.
- Adds features the single-level controller lacks:
  - configurable minute-digit count and tick rate;
  - selectable power levels, implemented as a magnetron duty cycle;
  - pause/resume;
  - an explicit DONE state.
- Sits at design top level: drives magnetron enable and raw BCD digits; external 7-segment decoders consume the digits.

Parameters:
- TICKS_PER_SEC, 100, clock cycles per countdown second (>=2).
- MIN_DIGITS, 1, number of BCD minute digits (1..3).
- POWER_LEVELS, 4, number of power levels and length of the duty frame in seconds (2..10).

Ports:
- clock  in  1  system clock, rising edge.
- clearn  in  1  asynchronous active-low reset.
- keypad  in  10  one-hot digit keys, bit k = digit k, active-high level.
- startn  in  1  start/resume button, active-low level.
- stopn  in  1  stop/pause button, active-low level.
- power_key  in  1  power-level step button, active-high level.
- door_closed  in  1  1 = door closed.
- mag_on  out  1  magnetron enable.
- sec_ones  out  4  BCD seconds units.
- sec_tens  out  4  BCD seconds tens.
- mins  out  4*MIN_DIGITS  BCD minutes, most significant digit in top nibble.
- power_level  out  $clog2(POWER_LEVELS+1)  current level, 1..POWER_LEVELS.
- done  out  1  high while in DONE.
- state  out  3  FSM state encoding: IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4.

Behaviour:
- Reset (clearn=0, asynchronous):
  - state=IDLE; all digits 0; power_level=POWER_LEVELS;
  - mag_on=0, done=0; tick and slot counters 0;
  - all edge-detect registers reflect released inputs.
  - mag_on drops in the same instant clearn asserts, including mid-cook.
- Input events: every button is edge-detected on a registered copy; an event is valid the cycle after the edge.
  - key event = rising edge of keypad with exactly one bit set. Multi-bit patterns are ignored.
  - start event = falling edge of startn. stop event = falling edge of stopn. power event = rising edge of power_key.
- Priority within one cycle: stop > start > key > power.
- Key entry (IDLE, ENTRY, DONE only):
  - Digits shift left by one nibble: mins <- {mins, sec_tens} truncated to MIN_DIGITS nibbles; sec_tens <- sec_ones; sec_ones <- key value.
  - The top minute digit is discarded.
  - In DONE, all digits clear first, then the shift applies in the same cycle.
  - state -> ENTRY.
- Power event: in IDLE or ENTRY, power_level increments, wrapping POWER_LEVELS -> 1. In all other states it is ignored.
- FSM transitions:
  - IDLE/ENTRY:
    - start with door_closed=1 and time != 0 -> COOK; tick and slot counters cleared.
    - start with door open or time = 0 -> no change.
    - stop -> IDLE with all digits cleared.
  - COOK:
    - door_closed=0 -> PAUSED in the next cycle; door takes precedence over tick.
    - stop -> PAUSED.
    - Key events ignored.
  - PAUSED:
    - start with door_closed=1 -> COOK; tick counter cleared, slot counter kept.
    - stop -> IDLE with digits cleared.
    - Digits held.
  - DONE:
    - key -> ENTRY.
    - stop or start -> IDLE with digits cleared.
- Countdown (COOK only):
  - Tick counter 0..TICKS_PER_SEC-1. At terminal count, decrement time once and advance the slot counter, which wraps at POWER_LEVELS-1.
  - Decrement rules:
    - sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; each minute digit 0 -> 9 with borrow.
    - Entered sec_tens values 6..9 count down normally, e.g. 0:90 -> 0:89.
  - When the decrement produces all-zero time: state -> DONE in the same edge; mag_on=0 from that edge.
- mag_on = (state==COOK) && door_closed && (slot < power_level). It is registered, except that the door term is combinational so the interlock is immediate.
  - power_level=POWER_LEVELS gives continuous on.
  - power_level=1 gives on for 1 second of every POWER_LEVELS seconds.
- done = (state==DONE).

Test Plan:
- Entry and cook at full power:
  - Reset, TICKS_PER_SEC=4, MIN_DIGITS=1, POWER_LEVELS=4.
  - Press 1, 0, 5, then start with door closed.
  - Display reads 1:05, state=COOK, mag_on=1 continuously.
  - After 65*4 cycles: 0:00, state=DONE, done=1, mag_on=0.
- Borrow chain:
  - Load 2:00, start.
  - After 4 cycles: 1:59. After a further 240 cycles: 0:59.
- Power level 1:
  - Press power_key 1 time (4 -> 1), load 0:08, start.
  - mag_on high only in seconds 0 and 4 of the cook, low in the other six; DONE after 32 cycles.
- Door interlock and resume:
  - Cook 0:10; open door at cycle 9.
  - mag_on=0 same cycle; state=PAUSED next cycle; digits hold 0:08.
  - Close door: stays PAUSED. Start: COOK resumes from 0:08.
- Priority and ignored inputs:
  - In COOK, press keypad 7: digits unchanged.
  - Assert start and stop edges in the same cycle: state=PAUSED.
  - keypad=10'b0000000011: ignored in ENTRY.
  - Start with time 0:00: stays IDLE.
- Async reset mid-cook:
  - Pulse clearn low between clock edges during COOK.
  - mag_on=0 immediately; all digits 0, power_level=4, state=IDLE.
  - The first start after reset with time 0 is ignored.
